// File: rtl/shift_add_mul.sv
// Iterative unsigned shift-and-add multiplier, one WIDTH-bit adder.
// Operands in over valid/ready; 2*WIDTH product held until accepted.
module shift_add_mul #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] product_hi,
  output logic [WIDTH-1:0] product_lo
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] p_hi;
  logic [WIDTH-1:0] p_lo;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;

  assign addend = p_lo[0] ? mcand : '0;
  // The single shared adder; its carry becomes the new accumulator MSB.
  assign sum = {1'b0, p_hi} + {1'b0, addend};

  assign in_ready   = (state == IDLE);
  assign busy       = (state == RUN);
  assign out_valid  = (state == DONE);
  assign product_hi = p_hi;
  assign product_lo = p_lo;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mcand <= '0;
      p_hi  <= '0;
      p_lo  <= '0;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            mcand <= a;
            p_hi  <= '0;
            p_lo  <= b;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          p_hi <= sum[WIDTH:1];
          p_lo <= {sum[0], p_lo[WIDTH-1:1]};
          cnt  <= cnt + 1'b1;
          if (cnt == LAST)
            state <= DONE;
        end
        DONE: begin
          if (out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_mul.sv
// Scoreboard bench for shift_add_mul at WIDTH=32 and WIDTH=8.
// Stimulus pushes expected products; monitors compare on out_valid.
module tb_shift_add_mul;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        iv32 = 1'b0, or32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic        ir32, bz32, ov32;
  logic [31:0] hi32, lo32;

  logic        iv8 = 1'b0, or8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        ir8, bz8, ov8;
  logic [7:0]  hi8, lo8;

  int checks = 0;
  int errors = 0;

  logic [63:0] sb32[$];
  logic [15:0] sb8[$];

  shift_add_mul #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst),
    .in_valid(iv32), .in_ready(ir32),
    .a(a32), .b(b32),
    .busy(bz32), .out_valid(ov32), .out_ready(or32),
    .product_hi(hi32), .product_lo(lo32)
  );

  shift_add_mul #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(iv8), .in_ready(ir8),
    .a(a8), .b(b8),
    .busy(bz8), .out_valid(ov8), .out_ready(or8),
    .product_hi(hi8), .product_lo(lo8)
  );

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ov32) begin
      if (sb32.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected32: out_valid=1 expected 0");
      end else begin
        chk("prod32", {hi32, lo32}, sb32[0]);
        if (or32) void'(sb32.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (ov8) begin
      if (sb8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected8: out_valid=1 expected 0");
      end else begin
        chk("prod8", {48'd0, hi8, lo8}, {48'd0, sb8[0]});
        if (or8) void'(sb8.pop_front());
      end
    end
  end

  task automatic start32(input logic [31:0] x, y,
                         input logic [63:0] exp);
    int n = 0;
    while (!ir32 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("ready32", {63'd0, ir32}, 64'd1);
    iv32 = 1'b1; a32 = x; b32 = y;
    sb32.push_back(exp);
    @(posedge clk); #1;
    iv32 = 1'b0;
  endtask

  task automatic wait32(input logic do_chk);
    int k = 0;
    do begin
      @(posedge clk); #1; k++;
    end while (!ov32 && k < 100);
    if (do_chk) chk("lat32", 64'(k), 64'd32);
  endtask

  task automatic finish32(input int hold);
    repeat (hold) begin
      @(posedge clk); #1;
    end
    or32 = 1'b1;
    @(posedge clk); #1;
    or32 = 1'b0;
    chk("idle32", {62'd0, ir32, ov32}, 64'd2);
  endtask

  task automatic start8(input logic [7:0] x, y,
                        input logic [15:0] exp);
    int n = 0;
    while (!ir8 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("ready8", {63'd0, ir8}, 64'd1);
    iv8 = 1'b1; a8 = x; b8 = y;
    sb8.push_back(exp);
    @(posedge clk); #1;
    iv8 = 1'b0;
  endtask

  task automatic run8(input logic [7:0] x, y,
                      input logic [15:0] exp,
                      input logic do_chk);
    int k = 0;
    start8(x, y, exp);
    do begin
      @(posedge clk); #1; k++;
    end while (!ov8 && k < 100);
    if (do_chk) chk("lat8", 64'(k), 64'd8);
    else if (!ov8) chk("timeout8", 64'd0, 64'd1);
    or8 = 1'b1;
    @(posedge clk); #1;
    or8 = 1'b0;
  endtask

  initial begin
    int k;
    logic [7:0] x, y;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctl32", {61'd0, ir32, bz32, ov32}, 64'd4);
    chk("rst_prod32", {hi32, lo32}, 64'd0);
    chk("rst_ctl8", {61'd0, ir8, bz8, ov8}, 64'd4);
    rst = 1'b0;

    start32(32'd3, 32'd5, 64'd15);
    chk("busy32", {63'd0, bz32}, 64'd1);
    wait32(1'b1);
    finish32(0);

    start32(32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
    wait32(1'b1);
    finish32(0);

    start32(32'h80000000, 32'd2, 64'h00000001_00000000);
    wait32(1'b1);
    finish32(0);

    start32(32'h12345678, 32'h9ABCDEF0, 64'h0B00EA4E_242D2080);
    wait32(1'b1);
    finish32(10);

    start32(32'd0, 32'hDEADBEEF, 64'd0);
    wait32(1'b1);
    finish32(0);

    start32(32'd7, 32'd6, 64'd42);
    k = 0;
    do begin
      @(posedge clk); #1; k++;
      if (k == 4) begin
        iv32 = 1'b1; a32 = 32'hFFFF; b32 = 32'hFFFF;
      end
    end while (!ov32 && k < 100);
    chk("lat32_ign", 64'(k), 64'd32);
    repeat (2) begin
      @(posedge clk); #1;
    end
    or32 = 1'b1;
    @(posedge clk); #1;
    or32 = 1'b0;
    chk("gap_idle", {62'd0, ir32, bz32}, 64'd2);
    sb32.push_back(64'h00000000_FFFE0001);
    @(posedge clk); #1;
    iv32 = 1'b0;
    chk("gap_run", {62'd0, ir32, bz32}, 64'd1);
    wait32(1'b0);
    finish32(0);

    start32(32'h00001234, 32'h00005678, 64'h00000000_06260060);
    repeat (16) @(posedge clk);
    #1;
    rst = 1'b1;
    sb32.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_ctl", {61'd0, ir32, bz32, ov32}, 64'd4);
    chk("abort_prod", {hi32, lo32}, 64'd0);
    k = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ov32) k++;
    end
    chk("abort_novalid", 64'(k), 64'd0);
    start32(32'd9, 32'd9, 64'd81);
    wait32(1'b1);
    finish32(0);

    run8(8'hFF, 8'hFF, 16'hFE01, 1'b1);
    run8(8'h0C, 8'h0D, 16'd156, 1'b1);
    for (int i = 0; i < 256; i++) begin
      x = 8'($urandom_range(0, 255));
      y = 8'($urandom_range(0, 255));
      run8(x, y, {8'd0, x} * {8'd0, y}, 1'b0);
    end
    repeat (3) @(posedge clk);
    chk("sb32_empty", 64'(sb32.size()), 64'd0);
    chk("sb8_empty", 64'(sb8.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_add_mul.md
# shift_add_mul

Iterative unsigned multiplier that time-shares one WIDTH-bit adder, with carry-out kept, over WIDTH cycles instead of instantiating a combinational array multiplier. Sits beside the ALU in the execute stage, next to the 32-bit adder datapath. It accepts an operand pair over a valid/ready handshake, sequences the shift-and-add iterations, and holds the 2·WIDTH-bit product until the consumer accepts it. Intended consumer is an execute-stage stall controller for multi-cycle MUL/MULHU.

## Interface
- WIDTH, 32, operand width; legal values are 4 or more, typically 8 or 32
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands (IDLE)
- a  in  WIDTH  multiplicand, unsigned
- b  in  WIDTH  multiplier, unsigned
- busy  out  1  iteration in progress (RUN)
- out_valid  out  1  product valid (DONE)
- out_ready  in  1  consumer accepts product
- product_hi  out  WIDTH  upper half of a·b
- product_lo  out  WIDTH  lower half of a·b

One clock; reset is synchronous and active-high.

## Operation
**Registers**
- mcand (WIDTH)
- P (2·WIDTH): P_hi is the accumulator, P_lo is the multiplier, shifted out LSB-first
- cnt, $clog2(WIDTH)+1 bits
- state ∈ {IDLE, RUN, DONE}

**Outputs**
- in_ready = (state==IDLE)
- busy = (state==RUN)
- out_valid = (state==DONE)
- {product_hi, product_lo} = P, driven in all states; only meaningful while out_valid=1

**IDLE**
- On in_valid=1 at a clock edge:
  - mcand←a
  - P_hi←0
  - P_lo←b
  - cnt←0
  - state→RUN
- Otherwise hold.

**RUN, each edge**
- sum[WIDTH:0] = P_lo[0] ? ({1'b0,P_hi} + mcand) : {1'b0,P_hi}.
- P ← {sum, P_lo[WIDTH-1:1]}: a right shift by 1 with the adder carry entering at the MSB.
- cnt←cnt+1.
- When cnt==WIDTH-1 on this edge, state→DONE.
- Exactly one adder is instantiated; its carry-out must never be dropped.

**DONE**
- P is held stable.
- On out_ready=1 at an edge, state→IDLE.
- out_ready is ignored in every other state.

**Boundary conditions**
- in_valid while in RUN or DONE: ignored. Operands are not latched, and a, b, mcand and P are unaffected.
- a or b equal to 0: still takes the full WIDTH iterations; there is no early termination. The product is 0.
- Maximum operands (2^WIDTH−1)²: the carry-out is required for a correct upper half.
- Same edge as a DONE→IDLE handshake: the block cannot accept new operands, because in_ready is 0 in DONE. Back-to-back operations are therefore separated by one IDLE cycle.
- rst=1 at any edge, including mid-RUN or in DONE:
  - state→IDLE; P, mcand and cnt←0.
  - Any in-flight result is discarded and never presented.
  - rst has priority over every handshake.

## Timing
- Reset values, after the first edge with rst=1:
  - in_ready=1
  - busy=0
  - out_valid=0
  - product_hi=product_lo=0
- Input acceptance at edge E0. Iterations happen on edges E1..E_WIDTH.
- busy is high in the cycles between E0 and E_WIDTH.
- out_valid goes high right after E_WIDTH, so latency from acceptance to out_valid is WIDTH cycles.
- out_valid and the product stay stable until the edge where out_ready=1. in_ready rises in the following cycle.
- Minimum initiation interval is WIDTH+2 cycles: WIDTH in RUN, 1 in DONE, 1 in IDLE.
- All outputs are functions of registered state only. There is no combinational path from any input to any output.

## Test plan
- **Basic product, WIDTH=32.**
  - Stimulus: a=3, b=5, in_valid pulsed one cycle, out_ready=1.
  - Required: out_valid rises exactly 32 cycles after acceptance, product_hi=0, product_lo=15. in_ready returns 1 one cycle after the handshake.
- **Carry path, WIDTH=32.**
  - Stimulus: a=b=0xFFFFFFFF.
  - Required: product_hi=0xFFFFFFFE, product_lo=0x00000001.
  - Also run a=0x80000000, b=2: required product_hi=1, product_lo=0.
- **Backpressure.**
  - Stimulus: a=0x12345678, b=0x9ABCDEF0, out_ready held 0 for 10 cycles after out_valid.
  - Required: out_valid and {hi,lo}=0x0B00EA4E_242D2080 stay stable all 10 cycles; the handshake completes on the first out_ready=1 edge.
- **Ignored request.**
  - Stimulus: start a=7, b=6. In RUN cycle 5 and in DONE, drive in_valid=1 with a=b=0xFFFF.
  - Required: result is 42, then exactly one IDLE cycle with in_ready=1 before the next acceptance.
- **Reset mid-operation.**
  - Stimulus: assert rst for one cycle at RUN cycle 17.
  - Required: next cycle in_ready=1, busy=0, out_valid=0, product=0, and no out_valid ever appears for the aborted operation. A new 9×9 request then yields 81.
- **Parameter sweep, WIDTH=8.**
  - Stimulus: 0xFF×0xFF, then 256 random pairs compared against a reference product.
  - Required: 0xFF×0xFF gives product_hi=0xFE, product_lo=0x01 with 8-cycle latency; all random pairs match the reference product.
